// File: rtl/pwm_ramp_ctrl.sv
// Soft-start/soft-stop duty controller for a 10-step PWM generator.
// Steps duty toward the switch target at period boundaries and owns the output enable.
module pwm_ramp_ctrl #(
    parameter int unsigned PERIOD       = 10,
    parameter int unsigned STEP_PERIODS = 4,
    parameter int unsigned DW           = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [2:0]    sw_i,
    input  logic          start_i,
    input  logic          stop_i,
    output logic [DW-1:0] duty_o,
    output logic          pwm_en_o,
    output logic          period_start_o,
    output logic          busy_o,
    output logic          at_target_o
);

    localparam int unsigned PcntW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int unsigned StepW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;

    typedef enum logic [1:0] {StOff, StRamp, StHold, StStopping} state_e;

    state_e           state_q;
    logic [2:0]       sw_meta_q, sw_sync_q;
    logic [PcntW-1:0] pcnt_q;
    logic [StepW-1:0] stepcnt_q;
    logic [DW-1:0]    duty_q;
    logic             pwm_en_q, busy_q, at_target_q;

    logic [DW-1:0]    target;
    logic [DW-1:0]    duty_ramp, duty_down;
    logic             period_end, step_evt;

    assign target     = DW'(sw_sync_q) + DW'(1);
    assign period_end = (pcnt_q == PcntW'(PERIOD - 1));
    assign step_evt   = period_end && (stepcnt_q == StepW'(STEP_PERIODS - 1));

    // Step is suppressed once duty already sits on its goal, so no wrap or underflow.
    always_comb begin
        duty_ramp = duty_q;
        if (duty_q < target) begin
            duty_ramp = duty_q + DW'(1);
        end else if (duty_q > target) begin
            duty_ramp = duty_q - DW'(1);
        end
        duty_down = (duty_q == '0) ? '0 : duty_q - DW'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StOff;
            sw_meta_q   <= '0;
            sw_sync_q   <= '0;
            pcnt_q      <= '0;
            stepcnt_q   <= '0;
            duty_q      <= '0;
            pwm_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            at_target_q <= 1'b0;
        end else begin
            sw_meta_q <= sw_i;
            sw_sync_q <= sw_meta_q;
            pcnt_q    <= period_end ? '0 : pcnt_q + PcntW'(1);

            unique case (state_q)
                StOff: begin
                    stepcnt_q <= '0;
                    if (start_i && !stop_i) begin
                        state_q  <= StRamp;
                        pwm_en_q <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                StRamp: begin
                    if (stop_i) begin
                        state_q   <= StStopping;
                        stepcnt_q <= '0;
                    end else if (step_evt) begin
                        duty_q    <= duty_ramp;
                        stepcnt_q <= '0;
                        if (duty_ramp == target) begin
                            state_q     <= StHold;
                            busy_q      <= 1'b0;
                            at_target_q <= 1'b1;
                        end
                    end else if (period_end) begin
                        stepcnt_q <= stepcnt_q + StepW'(1);
                    end
                end
                StHold: begin
                    stepcnt_q <= '0;
                    if (stop_i) begin
                        state_q     <= StStopping;
                        busy_q      <= 1'b1;
                        at_target_q <= 1'b0;
                    end else if (target != duty_q) begin
                        state_q     <= StRamp;
                        busy_q      <= 1'b1;
                        at_target_q <= 1'b0;
                    end
                end
                StStopping: begin
                    if (start_i && !stop_i) begin
                        state_q   <= StRamp;
                        stepcnt_q <= '0;
                    end else if (step_evt) begin
                        duty_q    <= duty_down;
                        stepcnt_q <= '0;
                        if (duty_down == '0) begin
                            state_q  <= StOff;
                            pwm_en_q <= 1'b0;
                            busy_q   <= 1'b0;
                        end
                    end else if (period_end) begin
                        stepcnt_q <= stepcnt_q + StepW'(1);
                    end
                end
                default: begin
                    state_q <= StOff;
                end
            endcase
        end
    end

    // Gated by reset so every output reads 0 while reset is held.
    assign period_start_o = (pcnt_q == '0) && !rst_i;
    assign duty_o         = duty_q;
    assign pwm_en_o       = pwm_en_q;
    assign busy_o         = busy_q;
    assign at_target_o    = at_target_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: per-cycle comparison against a behavioural model,
// plus directed scenarios with hand-computed expectations.
module tb_pwm_ramp_ctrl;

    localparam int PERIOD = 10;
    localparam int STEPS  = 4;
    localparam int M_OFF  = 0;
    localparam int M_RAMP = 1;
    localparam int M_HOLD = 2;
    localparam int M_STOP = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] sw = 3'd0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [3:0] duty;
    logic       pwm_en, period_start, busy, at_target;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;
    bit watch_en = 1'b0;
    bit en_drop  = 1'b0;

    pwm_ramp_ctrl #(.PERIOD(PERIOD), .STEP_PERIODS(STEPS), .DW(4)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .sw_i           (sw),
        .start_i        (start),
        .stop_i         (stop),
        .duty_o         (duty),
        .pwm_en_o       (pwm_en),
        .period_start_o (period_start),
        .busy_o         (busy),
        .at_target_o    (at_target)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Behavioural model: mode, duty, periods elapsed since mode entry, cycle count.
    int m_mode, m_duty, m_pe, m_cyc, m_sw1, m_sw2;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = M_OFF; m_duty = 0; m_pe = 0; m_cyc = 0; m_sw1 = 0; m_sw2 = 0;
        end else begin
            int  tgt;
            bit  pend;
            tgt  = m_sw2 + 1;
            pend = (m_cyc % PERIOD) == PERIOD - 1;
            case (m_mode)
                M_OFF: if (start && !stop) begin m_mode = M_RAMP; m_pe = 0; end
                M_RAMP: begin
                    if (stop) begin
                        m_mode = M_STOP; m_pe = 0;
                    end else if (pend) begin
                        m_pe++;
                        if (m_pe == STEPS) begin
                            m_pe = 0;
                            if (m_duty < tgt) m_duty++;
                            else if (m_duty > tgt) m_duty--;
                            if (m_duty == tgt) m_mode = M_HOLD;
                        end
                    end
                end
                M_HOLD: begin
                    if (stop) begin m_mode = M_STOP; m_pe = 0; end
                    else if (tgt != m_duty) begin m_mode = M_RAMP; m_pe = 0; end
                end
                default: begin
                    if (start && !stop) begin
                        m_mode = M_RAMP; m_pe = 0;
                    end else if (pend) begin
                        m_pe++;
                        if (m_pe == STEPS) begin
                            m_pe = 0;
                            if (m_duty > 0) m_duty--;
                            if (m_duty == 0) m_mode = M_OFF;
                        end
                    end
                end
            endcase
            m_cyc++;
            m_sw2 = m_sw1;
            m_sw1 = int'(sw);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_duty", int'(duty), m_duty);
            chk("model_pwm_en", int'(pwm_en), int'(m_mode != M_OFF));
            chk("model_busy", int'(busy), int'(m_mode == M_RAMP || m_mode == M_STOP));
            chk("model_at_target", int'(at_target), int'(m_mode == M_HOLD));
            chk("model_period_start", int'(period_start), int'(!rst && (m_cyc % PERIOD == 0)));
            if (watch_en && !pwm_en) en_drop = 1'b1;
        end
    end

    initial begin
        int k;
        int prev;
        // Reset behaviour
        #3 rst = 1'b1;
        #1 chk_en = 1'b1;
        chk("rst_duty", int'(duty), 0);
        chk("rst_pwm_en", int'(pwm_en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_at_target", int'(at_target), 0);
        chk("rst_period_start", int'(period_start), 0);
        sw = 3'b011;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("pstart_first", int'(period_start), 1);
        for (int i = 1; i < 21; i++) begin
            tick(1);
            chk("pstart_cadence", int'(period_start), int'(i % 10 == 0));
        end

        // Ramp up to 4 with start sampled at pcnt==0
        k = 0;
        while (!period_start && k < 20) begin tick(1); k++; end
        chk("align_pcnt0", int'(period_start), 1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("up_busy", int'(busy), 1);
        chk("up_pwm_en", int'(pwm_en), 1);
        tick(38);
        chk("up_duty_t39", int'(duty), 0);
        tick(1);
        chk("up_duty_t40", int'(duty), 1);
        chk("up_pstart_t40", int'(period_start), 1);
        tick(40);
        chk("up_duty_t80", int'(duty), 2);
        tick(40);
        chk("up_duty_t120", int'(duty), 3);
        chk("up_hold_t120", int'(at_target), 0);
        tick(40);
        chk("up_duty_t160", int'(duty), 4);
        chk("up_at_target", int'(at_target), 1);
        chk("up_busy_done", int'(busy), 0);

        // Retarget in HOLD: 4 -> 1
        tick(3);
        sw = 3'b000;
        tick(2);
        chk("retgt_busy_u2", int'(busy), 0);
        tick(1);
        chk("retgt_busy_u3", int'(busy), 1);
        k = 0;
        while (!at_target && k < 200) begin tick(1); k++; end
        chk("retgt_hold", int'(at_target), 1);
        chk("retgt_duty", int'(duty), 1);

        // Ramp to 8, stop, abort at 6
        sw = 3'b111;
        k = 0;
        while (!(at_target && duty == 4'd8) && k < 400) begin tick(1); k++; end
        chk("hold8_reached", int'(at_target && duty == 4'd8), 1);
        watch_en = 1'b1;
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        chk("abort_busy", int'(busy), 1);
        k = 0;
        while (duty != 4'd6 && k < 100) begin tick(1); k++; end
        chk("abort_duty6", int'(duty), 6);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        k = 0;
        while (!at_target && k < 200) begin tick(1); k++; end
        chk("abort_back8", int'(duty), 8);
        watch_en = 1'b0;
        chk("abort_en_kept", int'(en_drop), 0);

        // Full stop from duty 2, start+stop together
        sw = 3'b001;
        tick(3);
        k = 0;
        while (!(at_target && duty == 4'd2) && k < 400) begin tick(1); k++; end
        chk("hold2_reached", int'(at_target && duty == 4'd2), 1);
        start = 1'b1;
        stop = 1'b1;
        tick(1);
        start = 1'b0;
        stop = 1'b0;
        chk("prio_busy", int'(busy), 1);
        chk("prio_at_target", int'(at_target), 0);
        k = 0;
        prev = int'(duty);
        while (pwm_en && k < 120) begin prev = int'(duty); tick(1); k++; end
        chk("fstop_en_off", int'(pwm_en), 0);
        chk("fstop_duty0", int'(duty), 0);
        chk("fstop_prev1", prev, 1);
        chk("fstop_busy", int'(busy), 0);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        tick(2);
        chk("off_stop_ign", int'(pwm_en), 0);
        start = 1'b1;
        stop = 1'b1;
        tick(1);
        start = 1'b0;
        stop = 1'b0;
        chk("off_both_ign", int'(busy), 0);
        sw = 3'b111;
        tick(3);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("off_start_en", int'(pwm_en), 1);
        chk("off_start_busy", int'(busy), 1);

        // Reset mid-ramp at duty 5
        k = 0;
        while (duty != 4'd5 && k < 260) begin tick(1); k++; end
        chk("midramp_duty5", int'(duty), 5);
        chk("midramp_busy", int'(busy), 1);
        #3 rst = 1'b1;
        #1;
        chk("midrst_duty", int'(duty), 0);
        chk("midrst_pwm_en", int'(pwm_en), 0);
        chk("midrst_busy", int'(busy), 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        tick(100);
        chk("post_rst_off", int'(pwm_en), 0);
        chk("post_rst_duty", int'(duty), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
